// File: rtl/ps2_key_decoder_if.sv
// Key event bus from the PS/2 decoder to the core's keyboard handlers.
// ps2_key[10] toggles once per event; frame_err is a one-cycle pulse.
interface ps2_key_decoder_if;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (output ps2_key, output frame_err);
  modport slave  (input  ps2_key, input  frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframing and
// scan-code set 2 prefix folding into one toggle-signalled key event per make/break.
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 48000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_key_decoder_if.master   key_if
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state, state_nxt;
  logic               clk_s1, clk_s2, dat_s1, dat_s2;
  logic               clk_f, fall;
  logic [FCNT_W-1:0]  filt_cnt;
  logic [TMO_W-1:0]   idle_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [7:0]         shift_q;
  logic               par_q;
  logic               ext, brk;
  logic [10:0]        key_q;
  logic               err_q;
  logic               tmo_c, start_c, shift_c, par_c, stop_c;
  logic               byte_ok_c, frm_err_c, discard_c;

  // Two-flop synchronizers; idle-high lines reset to 1.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Clock deglitcher: a new level must persist FILTER_LEN cycles to be accepted.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_f    <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != clk_f) begin
        if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
          clk_f    <= clk_s2;
          filt_cnt <= '0;
          fall     <= clk_f;
        end else begin
          filt_cnt <= filt_cnt + FCNT_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign tmo_c = (state != S_IDLE) && !fall && (idle_cnt == TMO_W'(TIMEOUT));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tmo_c) begin
      state_nxt = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == BIT_W'(7)) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_c = 1'b0;
    shift_c = 1'b0;
    par_c   = 1'b0;
    stop_c  = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE:   start_c = !dat_s2;
        S_DATA:   shift_c = 1'b1;
        S_PARITY: par_c   = 1'b1;
        S_STOP:   stop_c  = 1'b1;
        default:  start_c = 1'b0;
      endcase
    end
  end

  // Odd parity over data plus parity bit, and a high stop bit.
  assign byte_ok_c = stop_c && dat_s2 && (^{shift_q, par_q});
  assign frm_err_c = (stop_c && !byte_ok_c) || tmo_c;
  assign discard_c = shift_q inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      ext      <= 1'b0;
      brk      <= 1'b0;
      key_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= frm_err_c;
      if (state == S_IDLE || fall) idle_cnt <= '0;
      else                         idle_cnt <= idle_cnt + TMO_W'(1);
      if (start_c) bit_cnt <= '0;
      if (shift_c) begin
        shift_q <= {dat_s2, shift_q[7:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (par_c) par_q <= dat_s2;
      // Prefixes accumulate until a real code arrives; any frame error drops them.
      if (frm_err_c) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_ok_c) begin
        if (shift_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk <= 1'b1;
        end else if (!discard_c) begin
          key_q <= {~key_q[10], ~brk, ext, shift_q};
          ext   <= 1'b0;
          brk   <= 1'b0;
        end
      end
    end
  end

  assign key_if.ps2_key   = key_q;
  assign key_if.frame_err = err_q;

endmodule
